key_event_arbiter: RTL and testbench

//  Front-end controller for N active-low push-buttons. Per key: synchronise, debounce, detect presses.

---
 rtl/key_event_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_key_event_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_arbiter.sv
// key_event_arbiter
// Front end for N active-low push-buttons: two-flop synchroniser, per-key
// debounce, press detection, one pending press per key and a round-robin
// arbiter that serialises presses onto a single valid/ready event stream.
// evt_lost flags (sticky) a press that arrived while the same key was still
// pending and not being granted.
// Optional feature: define KEY_AUTO_REPEAT_EN to enable per-key hold
// counters that raise auto-repeat events (evt_rpt = 1) after LONG_CYCLES
// and then every REPEAT_CYCLES while the key stays pressed.

module key_event_arbiter #(
    parameter int          N_KEYS        = 4,
    parameter int          DEB_CYCLES    = 50000,
    parameter logic [23:0] LONG_CYCLES   = 24'd10_000_000,
    parameter logic [23:0] REPEAT_CYCLES = 24'd2_500_000,
    localparam int         IDW           = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [IDW-1:0]    evt_key,
    output logic              evt_rpt,
    output logic [N_KEYS-1:0] evt_lost
);

    localparam int          IDX_W    = IDW + 1;
    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

    logic [N_KEYS-1:0] sync1_r;
    logic [N_KEYS-1:0] sync2_r;
    logic [N_KEYS-1:0] key_state_d_r;
    logic [15:0]       deb_cnt_r [N_KEYS];
    logic [N_KEYS-1:0] pending_r;
    logic [IDW-1:0]    ptr_r;

    logic [N_KEYS-1:0] press_s;
    logic [N_KEYS-1:0] rpt_set_s;
    logic [N_KEYS-1:0] grant_s;
    logic [IDX_W-1:0]  pick_s;
    logic              any_s;
    logic [IDW-1:0]    winner_s;
    logic              load_s;
    logic [IDW-1:0]    next_ptr_s;
    logic              win_rpt_s;

    // Round-robin search: first set request at ptr, ptr+1, ... with wrap.
    // Returns {found, index}.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_KEYS-1:0] req,
        input logic [IDW-1:0]    ptr
    );
        logic             found;
        logic [IDW-1:0]   sel;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            idx = {1'b0, ptr} + IDX_W'(k);
            if (idx >= IDX_W'(N_KEYS)) begin
                idx = idx - IDX_W'(N_KEYS);
            end else begin
                idx = idx;
            end
            if (!found && req[idx[IDW-1:0]]) begin
                found = 1'b1;
                sel   = idx[IDW-1:0];
            end else begin
                found = found;
            end
        end
        return {found, sel};
    endfunction

    // Two-flop synchroniser; idle level is 1 (released).
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '1;
            sync2_r <= '1;
        end else begin
            sync1_r <= key_in;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES stable differing samples.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            key_state     <= '1;
            key_state_d_r <= '1;
            for (int i = 0; i < N_KEYS; i++) begin
                deb_cnt_r[i] <= 16'd0;
            end
        end else begin
            key_state_d_r <= key_state;
            for (int i = 0; i < N_KEYS; i++) begin
                if (sync2_r[i] == key_state[i]) begin
                    deb_cnt_r[i] <= 16'd0;
                end else if (deb_cnt_r[i] == DEB_LAST) begin
                    key_state[i] <= sync2_r[i];
                    deb_cnt_r[i] <= 16'd0;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + 16'd1;
                end
            end
        end
    end

    // A press is the debounced level falling 1 -> 0.
    always_comb begin
        press_s = key_state_d_r & ~key_state;
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [23:0] RPT_WRAP = LONG_CYCLES + REPEAT_CYCLES;

    logic [23:0]       hold_cnt_r [N_KEYS];
    logic [N_KEYS-1:0] rpt_r;

    // Hold counters: first repeat at LONG_CYCLES, then every REPEAT_CYCLES.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_KEYS; i++) begin
                hold_cnt_r[i] <= 24'd0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (key_state[i]) begin
                    hold_cnt_r[i] <= 24'd0;
                end else if (hold_cnt_r[i] == RPT_WRAP) begin
                    hold_cnt_r[i] <= LONG_CYCLES + 24'd1;
                end else begin
                    hold_cnt_r[i] <= hold_cnt_r[i] + 24'd1;
                end
            end
        end
    end

    // Repeat request while held and the counter hits a repeat point.
    always_comb begin
        rpt_set_s = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (!key_state[i] &&
                ((hold_cnt_r[i] == LONG_CYCLES) || (hold_cnt_r[i] == RPT_WRAP))) begin
                rpt_set_s[i] = 1'b1;
            end else begin
                rpt_set_s[i] = 1'b0;
            end
        end
    end

    // Kind of the pending entry; merged repeats leave an existing entry alone.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rpt_r <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (press_s[i] && (!pending_r[i] || grant_s[i])) begin
                    rpt_r[i] <= 1'b0;
                end else if (rpt_set_s[i] && (!pending_r[i] || grant_s[i])) begin
                    rpt_r[i] <= 1'b1;
                end else begin
                    rpt_r[i] <= rpt_r[i];
                end
            end
        end
    end

    // Repeat flag of the arbitration winner.
    always_comb begin
        win_rpt_s = rpt_r[winner_s];
    end
`else
    logic unused_cfg_s;

    // Hold-time configuration only matters with auto-repeat built in.
    always_comb begin
        unused_cfg_s = ^{LONG_CYCLES, REPEAT_CYCLES};
    end

    // No repeat events in this build.
    always_comb begin
        rpt_set_s = '0;
        win_rpt_s = 1'b0;
    end
`endif

    // Arbitration: pick the next pending key when the output slot can take it.
    always_comb begin
        pick_s   = rr_pick(pending_r, ptr_r);
        any_s    = pick_s[IDW];
        winner_s = pick_s[IDW-1:0];
        load_s   = (~evt_valid | evt_ready) & any_s;
        grant_s  = '0;
        if (load_s) begin
            grant_s[winner_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
        if (winner_s == IDW'(N_KEYS - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = winner_s + IDW'(1);
        end
    end

    // Pending set/clear and sticky loss flags.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= '0;
            evt_lost  <= '0;
        end else begin
            pending_r <= (pending_r & ~grant_s) | press_s | rpt_set_s;
            evt_lost  <= evt_lost | (press_s & pending_r & ~grant_s);
        end
    end

    // Output slot and round-robin pointer.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_key   <= '0;
            evt_rpt   <= 1'b0;
            ptr_r     <= '0;
        end else if (load_s) begin
            evt_valid <= 1'b1;
            evt_key   <= winner_s;
            evt_rpt   <= win_rpt_s;
            ptr_r     <= next_ptr_s;
        end else if (evt_ready) begin
            evt_valid <= 1'b0;
        end else begin
            evt_valid <= evt_valid;
        end
    end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Self-checking bench for key_event_arbiter (N_KEYS=4, DEB_CYCLES=4,
// LONG=20, REPEAT=8). A behavioural model tracks the event stream and is
// compared every cycle; directed scenarios add literal expectations.

module tb_key_event_arbiter;

    localparam int N      = 4;
    localparam int DEB    = 4;
    localparam int LONG_I = 20;
    localparam int REP_I  = 8;

    logic         clk_in;
    logic         rst_n;
    logic [N-1:0] key_in;
    logic [N-1:0] key_state;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_key;
    logic         evt_rpt;
    logic [N-1:0] evt_lost;

    int n_vec = 0;
    int n_err = 0;

    key_event_arbiter #(
        .N_KEYS(N),
        .DEB_CYCLES(DEB),
        .LONG_CYCLES(24'(LONG_I)),
        .REPEAT_CYCLES(24'(REP_I))
    ) dut (
        .clk_in(clk_in),
        .rst_n(rst_n),
        .key_in(key_in),
        .key_state(key_state),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_key(evt_key),
        .evt_rpt(evt_rpt),
        .evt_lost(evt_lost)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_in);
            #1;
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_s1, m_s2, m_deb, m_fell, m_pend, m_rpt, m_lost;
    int           m_run [N];
    int           m_held [N];
    logic         m_valid, m_evrpt;
    int           m_key, m_ptr;

    always @(posedge clk_in or negedge rst_n) begin : model
        logic [N-1:0] n_pend, n_rpt, n_lost, n_deb, n_fell;
        int           n_run [N];
        int           n_held [N];
        logic         n_valid, n_evrpt, rep;
        int           n_key, n_ptr, grant, cand;
        if (!rst_n) begin
            m_s1 <= '1; m_s2 <= '1; m_deb <= '1; m_fell <= '0;
            m_pend <= '0; m_rpt <= '0; m_lost <= '0;
            m_valid <= 1'b0; m_evrpt <= 1'b0; m_key <= 0; m_ptr <= 0;
            for (int i = 0; i < N; i++) begin
                m_run[i]  <= 0;
                m_held[i] <= 0;
            end
        end else begin
            n_pend = m_pend; n_rpt = m_rpt; n_lost = m_lost; n_deb = m_deb;
            n_valid = m_valid; n_evrpt = m_evrpt; n_key = m_key; n_ptr = m_ptr;
            grant = -1;
            if ((!m_valid || evt_ready) && (m_pend != '0)) begin
                for (int k = 0; k < N; k++) begin
                    cand = (m_ptr + k) % N;
                    if (grant < 0 && m_pend[cand]) grant = cand;
                end
                n_valid = 1'b1; n_key = grant; n_evrpt = m_rpt[grant];
                n_ptr = (grant + 1) % N; n_pend[grant] = 1'b0;
            end else if (m_valid && evt_ready) begin
                n_valid = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (m_fell[i]) begin
                    if (m_pend[i] && grant != i) n_lost[i] = 1'b1;
                    else begin n_pend[i] = 1'b1; n_rpt[i] = 1'b0; end
                end
                n_held[i] = m_deb[i] ? 0 : m_held[i] + 1;
                rep = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
                rep = !m_deb[i] && (m_held[i] == LONG_I ||
                      (m_held[i] > LONG_I && ((m_held[i] - LONG_I) % REP_I) == 0));
`endif
                if (rep && !(m_pend[i] && grant != i)) begin
                    n_pend[i] = 1'b1; n_rpt[i] = 1'b1;
                end
                n_run[i] = (m_s2[i] != m_deb[i]) ? m_run[i] + 1 : 0;
                if (n_run[i] == DEB) begin
                    n_deb[i] = m_s2[i];
                    n_run[i] = 0;
                end
                n_fell[i] = m_deb[i] & ~n_deb[i];
            end
            m_s1 <= key_in; m_s2 <= m_s1; m_deb <= n_deb; m_fell <= n_fell;
            m_pend <= n_pend; m_rpt <= n_rpt; m_lost <= n_lost;
            m_valid <= n_valid; m_key <= n_key; m_evrpt <= n_evrpt; m_ptr <= n_ptr;
            for (int i = 0; i < N; i++) begin
                m_run[i]  <= n_run[i];
                m_held[i] <= n_held[i];
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_in) begin
        if (rst_n) begin
            check("key_state", 32'(key_state), 32'(m_deb));
            check("evt_valid", 32'(evt_valid), 32'(m_valid));
            if (m_valid) begin
                check("evt_key", 32'(evt_key), 32'(m_key));
                check("evt_rpt", 32'(evt_rpt), 32'(m_evrpt));
            end
            check("evt_lost", 32'(evt_lost), 32'(m_lost));
        end
    end

    // Log of accepted events.
    int   log_key [$];
    logic log_rpt [$];
    always @(posedge clk_in) begin
        if (rst_n && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            log_key.push_back(int'(evt_key));
            log_rpt.push_back(evt_rpt);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int base;
        key_in = 4'hF; evt_ready = 1'b0; rst_n = 1'b1;
        #1 rst_n = 1'b0;
        step(2);
        check("rst_key_state", 32'(key_state), 32'h0000_000F);
        check("rst_evt_valid", 32'(evt_valid), 32'h0);
        check("rst_evt_key",   32'(evt_key),   32'h0);
        check("rst_evt_rpt",   32'(evt_rpt),   32'h0);
        check("rst_evt_lost",  32'(evt_lost),  32'h0);
        rst_n = 1'b1;
        step(2);

        // Keys 0,1,3 together with ready high: 0,1,3 back-to-back.
        evt_ready = 1'b1;
        key_in = 4'b0100;
        step(7);  check("t3_idle_e7", 32'(evt_valid), 32'h0);
        step(1);  check("t3_k0", 32'({evt_valid, evt_key}), 32'h4);
        step(1);  check("t3_k1", 32'({evt_valid, evt_key}), 32'h5);
        step(1);  check("t3_k3", 32'({evt_valid, evt_key}), 32'h7);
        step(1);  check("t3_drain", 32'(evt_valid), 32'h0);
        key_in = 4'hF;
        step(10);
        check("t3_count", 32'(log_key.size()), 32'd3);
        if (log_key.size() == 3) check("t3_order", 32'((log_key[0] << 8) | (log_key[1] << 4) | log_key[2]), 32'h013);

        // Pointer back at 0: keys 1 and 2 together -> 1 then 2.
        key_in = 4'b1001;
        step(8);  check("t3b_k1", 32'({evt_valid, evt_key}), 32'h5);
        step(1);  check("t3b_k2", 32'({evt_valid, evt_key}), 32'h6);
        key_in = 4'hF;
        step(10);

        // Key 2 held 10 cycles: debounced after 6, event 2 cycles later, once.
        base = log_key.size();
        key_in = 4'b1011;
        step(5);  check("t1_ks_e5", 32'(key_state), 32'h0000_000F);
        step(1);  check("t1_ks_e6", 32'(key_state), 32'h0000_000B);
        step(1);  check("t1_idle_e7", 32'(evt_valid), 32'h0);
        step(1);  check("t1_evt", 32'({evt_valid, evt_rpt, evt_key}), 32'hA);
        step(2);
        key_in = 4'hF;
        step(10);
        check("t1_count", 32'(log_key.size() - base), 32'd1);
        if (log_key.size() == base + 1) check("t1_key", 32'(log_key[base]), 32'd2);

        // Key 1 glitch of 3 cycles: no level change, no event.
        base = log_key.size();
        key_in = 4'b1101;
        step(3);
        key_in = 4'hF;
        step(12);
        check("t2_ks", 32'(key_state), 32'h0000_000F);
        check("t2_count", 32'(log_key.size() - base), 32'd0);

        // Ready low: press key 3 three times; third press is lost.
        base = log_key.size();
        evt_ready = 1'b0;
        key_in = 4'b0111; step(8);
        check("t4_held", 32'({evt_valid, evt_key}), 32'h7);
        key_in = 4'hF; step(8);
        key_in = 4'b0111; step(8);
        key_in = 4'hF; step(8);
        check("t4_no_lost_yet", 32'(evt_lost), 32'h0);
        key_in = 4'b0111; step(8);
        check("t4_lost", 32'(evt_lost), 32'h0000_0008);
        check("t4_still_held", 32'({evt_valid, evt_key}), 32'h7);
        key_in = 4'hF; step(8);
        evt_ready = 1'b1;
        step(5);
        check("t4_count", 32'(log_key.size() - base), 32'd2);
        check("t4_lost_sticky", 32'(evt_lost), 32'h0000_0008);

`ifdef KEY_AUTO_REPEAT_EN
        // Key 0 held: press event, then repeats 20, 28 and 36 cycles later.
        base = log_key.size();
        key_in = 4'b1110;
        step(8);  check("t6_press", 32'({evt_valid, evt_rpt, evt_key}), 32'h8);
        step(20); check("t6_rpt1", 32'({evt_valid, evt_rpt, evt_key}), 32'hC);
        step(16);
        key_in = 4'hF;
        step(12);
        check("t6_count", 32'(log_key.size() - base), 32'd4);
        if (log_rpt.size() == base + 4)
            check("t6_rpt_seq", 32'({log_rpt[base], log_rpt[base+1], log_rpt[base+2], log_rpt[base+3]}), 32'h7);
`endif

        // Reset with an event in flight and two keys pending.
        base = log_key.size();
        evt_ready = 1'b0;
        key_in = 4'b1000;
        step(9);
        check("t5_inflight", 32'(evt_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_ks",    32'(key_state), 32'h0000_000F);
        check("t5_rst_valid", 32'(evt_valid), 32'h0);
        check("t5_rst_key",   32'(evt_key),   32'h0);
        check("t5_rst_rpt",   32'(evt_rpt),   32'h0);
        check("t5_rst_lost",  32'(evt_lost),  32'h0);
        key_in = 4'hF;
        evt_ready = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(20);
        check("t5_no_stale", 32'(log_key.size() - base), 32'd0);

        // Normal operation after reset: key 1 press.
        key_in = 4'b1101;
        step(8);  check("t5_after", 32'({evt_valid, evt_key}), 32'h5);
        key_in = 4'hF;
        step(10);
        check("t5_after_count", 32'(log_key.size() - base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
